branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer plus 2-bit prediction table for the 5-stage MIPS pipeline; the storage side of the branch unit's H/P/Hd/Pd/WRt/WRp interface.
- IF stage: looks up the fetch PC and returns hit (H), prediction (P) and predicted target.
- Registered copies (Hd, Pd, target_d) travel to ID alongside the branch.
- Consumes WRt (allocate tag/target) and WRp (train counter) from the branch unit.

Parameters:
- ENTRIES, 16, number of table entries (power of two).
- INDEX_W, 4, log2(ENTRIES); index = pc_if[INDEX_W+1:2].
- TAG_W, 26, tag = pc[31:INDEX_W+2]; must equal 30-INDEX_W.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- pc_if  in  32  fetch PC (IF stage).
- H  out  1  lookup hit: entry valid and tag match (combinational).
- P  out  1  predict taken: counter[1] of the hit entry; 0 when H=0.
- target  out  32  stored target of the hit entry; 0 when H=0.
- stall  in  1  hold the IF->ID registers.
- flush  in  1  clear the IF->ID registers (from branch unit).
- Hd  out  1  H registered into ID.
- Pd  out  1  P registered into ID.
- target_d  out  32  target registered into ID.
- WRt  in  1  allocate/overwrite entry for upd_pc.
- WRp  in  1  train counter of entry for upd_pc.
- upd_pc  in  32  PC of the branch resolved in ID.
- upd_target  in  32  computed branch target.
- upd_taken  in  1  resolved outcome (beq condition).
- lookups  out  CNT_W  count of cycles with stall=0 (saturating).
- hits  out  CNT_W  count of those cycles with H=1 (saturating).

Behaviour:
- Per-entry state: valid, tag[TAG_W], target[32], cnt[2] (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Reset (reset=0 at clock edge): all valid=0, cnt=01, tag/target=0; Hd=Pd=0, target_d=0; lookups=hits=0. Reset wins over all other inputs, including mid-update.
- Lookup: purely combinational from pc_if and the current array contents. pc_if[1:0] ignored.
- Read-during-write: a lookup in the cycle of a write to the same index sees the OLD contents; the new value is visible the next cycle. No bypass.
- IF->ID register, priority flush > stall > load:
  - flush=1: Hd=0, Pd=0, target_d=0.
  - stall=1 (flush=0): hold.
  - else: load H, P, target.
- WRt=1: entry[upd_pc index] gets valid=1, tag, target=upd_target, cnt = upd_taken ? 10 : 01. Overwrites any previous occupant (aliasing eviction).
- WRp=1 with WRt=0: only if the entry is valid and its tag matches upd_pc. cnt += 1 saturating at 11 if upd_taken, else cnt -= 1 saturating at 00. A miss is silently ignored.
- WRt and WRp both 1: allocation rule applies; WRp is ignored.
- Writes are not gated by stall or flush; the branch unit qualifies them.
- Statistics: when stall=0, lookups increments; hits increments if H=1. Both saturate at all-ones. Not cleared by flush.
- Latency: H/P/target 0 cycles; Hd/Pd/target_d 1 cycle; table update visible 1 cycle after the write edge.

Decomposition:
- Shared package bp_pkg: counter encodings (CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11), PC_W=32, the index/tag slice helper widths, and the btb_entry_t struct {valid, tag, target, cnt}.
- One natural sub-module: sat_counter2, the 2-bit saturating up/down next-state function, reused later by a global-history predictor.
- Array, lookup, pipeline register and statistics stay in branch_target_buffer.

Test Plan:
- Reset then pc_if=0x00400010 -> H=0, P=0, target=0; next cycle Hd=0; lookups=1, hits=0.
- WRt=1, upd_pc=0x00400010, upd_target=0x00400040, upd_taken=1; next cycle pc_if=0x00400010 -> H=1, P=1, target=0x00400040; one cycle later Hd=1, Pd=1, target_d=0x00400040.
- Training on that entry: starting cnt=10, WRp with upd_taken=0 twice -> cnt 01, then 00, P=0. Third NT -> stays 00. Three taken updates -> 01, 10, 11, P=1 after the second.
- Aliasing: allocate 0x00400010, then WRt for 0x00800010 (same index 4) -> lookup 0x00400010 gives H=0. WRp for 0x00400010 leaves the entry's cnt unchanged.
- Read-during-write: same cycle, pc_if=upd_pc=0x00400020 with WRt=1 -> H=0 that cycle, H=1 the next. Flush and stall asserted together -> Hd=Pd=0.
- Reset mid-operation: reset=0 in the same cycle as WRt=1 -> entry stays invalid and counters=0. Preload lookups=0xFFFF via a long run -> stays at 0xFFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions.
// Holds the 2-bit counter encodings, PC and table geometry, and the BTB entry
// layout used by the branch target buffer and other predictor blocks.
package bp_pkg;

    localparam int PC_W        = 32;
    localparam int BTB_ENTRIES = 16;
    localparam int BTB_INDEX_W = 4;
    // Word-aligned PC: bits [1:0] are dropped, the index comes next, the rest is tag.
    localparam int BTB_TAG_W   = PC_W - 2 - BTB_INDEX_W;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [PC_W-1:0]      target;
        logic [1:0]           cnt;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_RST = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        cnt:    CNT_WNT
    };

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating up/down counter, next-state function only.
// Ports:
//   cnt_i  current counter value
//   up_i   1 = count towards strong-taken, 0 = towards strong-not-taken
//   cnt_o  next counter value, clamped at 00 and 11
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       up_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            if (cnt_i != CNT_ST) begin
                cnt_o = cnt_i + 2'd1;
            end
        end else begin
            if (cnt_i != CNT_SNT) begin
                cnt_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry 2-bit prediction counter.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   pc_if                   fetch PC; H/P/target are its combinational lookup
//   stall, flush            control of the IF->ID copies Hd/Pd/target_d
//   WRt, WRp                allocate entry / train counter for upd_pc
//   upd_pc, upd_target,
//   upd_taken               resolved branch information from ID
//   lookups, hits           saturating statistics counters
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int INDEX_W = BTB_INDEX_W,
    parameter int TAG_W   = BTB_TAG_W,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      pc_if,
    output logic             H,
    output logic             P,
    output logic [31:0]      target,
    input  logic             stall,
    input  logic             flush,
    output logic             Hd,
    output logic             Pd,
    output logic [31:0]      target_d,
    input  logic             WRt,
    input  logic             WRp,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    output logic [CNT_W-1:0] lookups,
    output logic [CNT_W-1:0] hits
);

    btb_entry_t         table_q [ENTRIES];

    logic [INDEX_W-1:0] rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    btb_entry_t         rd_entry;

    logic [INDEX_W-1:0] wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    btb_entry_t         wr_entry;
    logic               wr_hit;
    logic [1:0]         cnt_trained;
    btb_entry_t         entry_d;
    logic               entry_we;

    logic               hd_q, hd_d;
    logic               pd_q, pd_d;
    logic [31:0]        tgt_q, tgt_d;
    logic [CNT_W-1:0]   lookups_q, lookups_d;
    logic [CNT_W-1:0]   hits_q, hits_d;

    logic               unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

    // Lookup reads the registered array directly, so a same-cycle write is
    // not visible until the following cycle.
    assign rd_idx   = pc_if[INDEX_W+1:2];
    assign rd_tag   = pc_if[PC_W-1:INDEX_W+2];
    assign rd_entry = table_q[rd_idx];

    assign H      = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign P      = H && rd_entry.cnt[1];
    assign target = H ? rd_entry.target : '0;

    assign wr_idx   = upd_pc[INDEX_W+1:2];
    assign wr_tag   = upd_pc[PC_W-1:INDEX_W+2];
    assign wr_entry = table_q[wr_idx];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

    sat_counter2 u_sat_counter2 (
        .cnt_i (wr_entry.cnt),
        .up_i  (upd_taken),
        .cnt_o (cnt_trained)
    );

    // Allocation takes precedence over training; training an entry owned by
    // a different branch (tag miss) is dropped.
    always_comb begin
        entry_d  = wr_entry;
        entry_we = 1'b0;
        if (WRt) begin
            entry_we       = 1'b1;
            entry_d.valid  = 1'b1;
            entry_d.tag    = wr_tag;
            entry_d.target = upd_target;
            entry_d.cnt    = upd_taken ? CNT_WT : CNT_WNT;
        end else if (WRp && wr_hit) begin
            entry_we    = 1'b1;
            entry_d.cnt = cnt_trained;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BTB_ENTRY_RST;
            end
        end else if (entry_we) begin
            table_q[wr_idx] <= entry_d;
        end
    end

    always_comb begin
        hd_d  = hd_q;
        pd_d  = pd_q;
        tgt_d = tgt_q;
        if (flush) begin
            hd_d  = 1'b0;
            pd_d  = 1'b0;
            tgt_d = '0;
        end else if (!stall) begin
            hd_d  = H;
            pd_d  = P;
            tgt_d = target;
        end
    end

    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        if (!stall) begin
            if (lookups_q != '1) begin
                lookups_d = lookups_q + CNT_W'(1);
            end
            if (H && (hits_q != '1)) begin
                hits_d = hits_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hd_q      <= 1'b0;
            pd_q      <= 1'b0;
            tgt_q     <= '0;
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            hd_q      <= hd_d;
            pd_q      <= pd_d;
            tgt_q     <= tgt_d;
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign Hd       = hd_q;
    assign Pd       = pd_q;
    assign target_d = tgt_q;
    assign lookups  = lookups_q;
    assign hits     = hits_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus a
// randomized phase, all compared against a table-of-integers reference model.
module tb_branch_target_buffer;

    logic        clock;
    logic        reset;
    logic [31:0] pc_if;
    logic        H, P;
    logic [31:0] target;
    logic        stall, flush;
    logic        Hd, Pd;
    logic [31:0] target_d;
    logic        WRt, WRp;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken;
    logic [15:0] lookups, hits;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_cnt   [16];
    bit          m_hd, m_pd;
    int unsigned m_tgtd;
    int unsigned m_lookups, m_hits;

    branch_target_buffer dut (
        .clock      (clock),
        .reset      (reset),
        .pc_if      (pc_if),
        .H          (H),
        .P          (P),
        .target     (target),
        .stall      (stall),
        .flush      (flush),
        .Hd         (Hd),
        .Pd         (Pd),
        .target_d   (target_d),
        .WRt        (WRt),
        .WRp        (WRp),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .lookups    (lookups),
        .hits       (hits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, obs, exp, $time);
        end
    endtask

    // One clock cycle: optionally compare every output with the model just
    // before the edge, then advance the model with the inputs seen at the edge.
    task automatic step(input bit chk);
        int          ri, wi;
        int unsigned rt, wt;
        bit          mh, mp;
        int unsigned mtg;
        @(negedge clock);
        ri  = int'((pc_if >> 2) & 32'hF);
        rt  = pc_if >> 6;
        mh  = m_valid[ri] && (m_tag[ri] == rt);
        mp  = mh && (m_cnt[ri] >= 2);
        mtg = mh ? m_tgt[ri] : 0;
        if (chk) begin
            check("H",        32'(H),        32'(mh));
            check("P",        32'(P),        32'(mp));
            check("target",   target,        mtg);
            check("Hd",       32'(Hd),       32'(m_hd));
            check("Pd",       32'(Pd),       32'(m_pd));
            check("target_d", target_d,      m_tgtd);
            check("lookups",  32'(lookups),  m_lookups);
            check("hits",     32'(hits),     m_hits);
        end
        @(posedge clock);
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
            end
            m_hd = 0; m_pd = 0; m_tgtd = 0; m_lookups = 0; m_hits = 0;
        end else begin
            if (flush) begin
                m_hd = 0; m_pd = 0; m_tgtd = 0;
            end else if (!stall) begin
                m_hd = mh; m_pd = mp; m_tgtd = mtg;
            end
            if (!stall) begin
                if (m_lookups < 65535) m_lookups++;
                if (mh && m_hits < 65535) m_hits++;
            end
            wi = int'((upd_pc >> 2) & 32'hF);
            wt = upd_pc >> 6;
            if (WRt) begin
                m_valid[wi] = 1; m_tag[wi] = wt; m_tgt[wi] = upd_target;
                m_cnt[wi] = upd_taken ? 2 : 1;
            end else if (WRp && m_valid[wi] && m_tag[wi] == wt) begin
                if (upd_taken) m_cnt[wi] = (m_cnt[wi] == 3) ? 3 : m_cnt[wi] + 1;
                else           m_cnt[wi] = (m_cnt[wi] == 0) ? 0 : m_cnt[wi] - 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        WRt = 0; WRp = 0; stall = 0; flush = 0;
    endtask

    task automatic wrt(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
        WRt = 1; WRp = 0; upd_pc = pc; upd_target = tg; upd_taken = tk;
        step(1);
        WRt = 0;
    endtask

    task automatic wrp(input logic [31:0] pc, input logic tk);
        WRt = 0; WRp = 1; upd_pc = pc; upd_taken = tk;
        step(1);
        WRp = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        pc_if = pc;
        #1;
    endtask

    initial begin
        int unsigned r;
        reset = 0; pc_if = 32'h0040_0010; upd_pc = 0; upd_target = 0; upd_taken = 0;
        idle();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        m_hd = 0; m_pd = 0; m_tgtd = 0; m_lookups = 0; m_hits = 0;
        #1;
        step(0);
        step(1);

        // reset state and first lookup
        reset = 1;
        look(32'h0040_0010);
        check("rst_H", 32'(H), 32'd0);
        check("rst_P", 32'(P), 32'd0);
        check("rst_target", target, 32'd0);
        step(1);
        check("rst_Hd", 32'(Hd), 32'd0);
        check("rst_lookups", 32'(lookups), 32'd1);
        check("rst_hits", 32'(hits), 32'd0);

        // allocate and look up
        wrt(32'h0040_0010, 32'h0040_0040, 1'b1);
        look(32'h0040_0010);
        check("alloc_H", 32'(H), 32'd1);
        check("alloc_P", 32'(P), 32'd1);
        check("alloc_target", target, 32'h0040_0040);
        step(1);
        check("alloc_Hd", 32'(Hd), 32'd1);
        check("alloc_Pd", 32'(Pd), 32'd1);
        check("alloc_target_d", target_d, 32'h0040_0040);

        // training: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11
        wrp(32'h0040_0010, 1'b0);
        check("train_wnt_P", 32'(P), 32'd0);
        wrp(32'h0040_0010, 1'b0);
        wrp(32'h0040_0010, 1'b0);
        wrp(32'h0040_0010, 1'b1);
        check("train_up1_P", 32'(P), 32'd0);
        wrp(32'h0040_0010, 1'b1);
        check("train_up2_P", 32'(P), 32'd1);
        wrp(32'h0040_0010, 1'b1);
        wrp(32'h0040_0010, 1'b1);
        check("train_sat_hi_P", 32'(P), 32'd1);
        wrp(32'h0040_0010, 1'b0);
        wrp(32'h0040_0010, 1'b0);
        check("train_down_P", 32'(P), 32'd0);

        // aliasing eviction
        wrt(32'h0080_0010, 32'h0080_0100, 1'b0);
        look(32'h0040_0010);
        check("alias_old_H", 32'(H), 32'd0);
        wrp(32'h0040_0010, 1'b1);
        wrp(32'h0040_0010, 1'b1);
        look(32'h0080_0010);
        check("alias_new_H", 32'(H), 32'd1);
        check("alias_new_P", 32'(P), 32'd0);
        check("alias_new_target", target, 32'h0080_0100);

        // read during write, then flush beats stall
        pc_if = 32'h0040_0020;
        WRt = 1; upd_pc = 32'h0040_0020; upd_target = 32'h0040_0200; upd_taken = 1;
        #1;
        check("rdw_same_H", 32'(H), 32'd0);
        step(1);
        WRt = 0;
        #1;
        check("rdw_next_H", 32'(H), 32'd1);
        step(1);
        check("load_Hd", 32'(Hd), 32'd1);
        stall = 1; flush = 1;
        step(1);
        check("flush_Hd", 32'(Hd), 32'd0);
        check("flush_Pd", 32'(Pd), 32'd0);
        check("flush_target_d", target_d, 32'd0);
        flush = 0; stall = 0;
        step(1);
        stall = 1; pc_if = 32'h0000_1000;
        step(1);
        check("stall_hold_Hd", 32'(Hd), 32'd1);
        check("stall_hold_target_d", target_d, 32'h0040_0200);
        stall = 0;

        // reset concurrent with an allocation
        reset = 0; WRt = 1; upd_pc = 32'h0040_0030; upd_target = 32'h1234_5678; upd_taken = 1;
        step(1);
        reset = 1; WRt = 0;
        look(32'h0040_0030);
        check("rstwr_H", 32'(H), 32'd0);
        check("rstwr_lookups", 32'(lookups), 32'd0);
        check("rstwr_hits", 32'(hits), 32'd0);
        step(1);

        // randomized traffic over a small PC pool to force hits and aliasing
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            pc_if      = 32'h0040_0000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 15) << 2) + (r & 3);
            upd_pc     = 32'h0040_0000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 15) << 2);
            upd_target = $urandom;
            upd_taken  = $urandom_range(0, 1);
            WRt        = ($urandom_range(0, 99) < 15);
            WRp        = ($urandom_range(0, 99) < 35);
            stall      = ($urandom_range(0, 99) < 20);
            flush      = ($urandom_range(0, 99) < 10);
            reset      = ($urandom_range(0, 999) >= 3);
            step(1);
        end
        idle();
        reset = 1;

        // saturate the lookup counter with a long run
        reset = 0;
        step(0);
        reset = 1;
        for (int n = 0; n < 65540; n++) begin
            pc_if = $urandom;
            step(0);
        end
        step(1);
        check("sat_lookups", 32'(lookups), 32'h0000_FFFF);
        step(1);
        check("sat_lookups_hold", 32'(lookups), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
